// File: rtl/i2c_bus_monitor_if.sv
// Bus-side signal bundle for the I2C bus monitor.
// scl_in/sda_in are the raw asynchronous pad lines. All other signals are the
// monitor's registered observations. The monitor uses the slave modport and
// the environment that owns the pads uses the master modport.
interface i2c_bus_monitor_if;
  logic       scl_in;
  logic       sda_in;
  logic       scl_f;
  logic       sda_f;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic       bus_busy;
  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       ack_valid;
  logic       ack_bit;

  modport master (
    output scl_in, sda_in,
    input  scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy,
           byte_valid, rx_byte, ack_valid, ack_bit
  );

  modport slave (
    input  scl_in, sda_in,
    output scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy,
           byte_valid, rx_byte, ack_valid, ack_bit
  );
endinterface

// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor. It synchronizes and glitch-filters SCL and SDA,
// detects START, repeated START and STOP conditions, and assembles data bytes
// and the acknowledge bit that follows each byte.
// Ports:
//   clk_400 : sole clock, rising edge
//   rst     : synchronous active-high reset
//   bus     : i2c_bus_monitor_if.slave. It carries the raw scl_in/sda_in lines
//             in, and carries the filtered lines, edge/event pulses, bus_busy,
//             rx_byte/byte_valid and ack_bit/ack_valid out.
module i2c_bus_monitor #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic               clk_400,
  input  logic               rst,
  i2c_bus_monitor_if.slave   bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LINES  = 2;   // index 0 = SCL, 1 = SDA

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(7);
  localparam logic [BIT_W-1:0] BIT_ACK  = BIT_W'(8);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  logic [LINES-1:0]  sync1, sync2, filt, filt_q;
  logic [CNT_W-1:0]  stab_cnt [LINES];

  state_t            state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BYTE_W-1:0] shreg;
  logic [BYTE_W-1:0] shift_c;
  logic              rise_c, fall_c, start_c, stop_c;

  logic              scl_rise_q, scl_fall_q, start_q, stop_q, busy_q;
  logic              byte_valid_q, ack_valid_q, ack_bit_q;
  logic [BYTE_W-1:0] rx_byte_q;

  // Two-flop synchronizer, then the per-line stability filter. The filtered
  // line follows only after the synchronized value has differed for FILTER_LEN
  // consecutive cycles.
  always_ff @(posedge clk_400) begin
    if (rst) begin
      sync1  <= '1;
      sync2  <= '1;
      filt   <= '1;
      filt_q <= '1;
      for (int i = 0; i < LINES; i++) stab_cnt[i] <= '0;
    end else begin
      sync1  <= {bus.sda_in, bus.scl_in};
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < LINES; i++) begin
        if (sync2[i] == filt[i]) begin
          stab_cnt[i] <= '0;
        end else if (stab_cnt[i] == CNT_LAST) begin
          filt[i]     <= sync2[i];
          stab_cnt[i] <= '0;
        end else begin
          stab_cnt[i] <= stab_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Edge and condition detection on the filtered lines. START and STOP need
  // SCL steady high across the SDA edge. If both lines move in the same cycle,
  // only the SCL edge is reported.
  always_comb begin
    rise_c  = filt[0] & ~filt_q[0];
    fall_c  = ~filt[0] & filt_q[0];
    start_c = filt[0] & filt_q[0] & filt_q[1] & ~filt[1];
    stop_c  = filt[0] & filt_q[0] & ~filt_q[1] & filt[1];
    // The cast keeps the low byte of {shreg, sda}, so the MSB shifts out.
    shift_c = BYTE_W'({shreg, filt[1]});
  end

  // Bus ownership FSM: busy from START until STOP.
  always_ff @(posedge clk_400) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_c)     state_d = ST_BUSY;
    else if (stop_c) state_d = ST_IDLE;
  end

  // Registered event pulses and frame assembly. START and STOP take priority
  // over any SCL rise in the same cycle.
  always_ff @(posedge clk_400) begin
    if (rst) begin
      scl_rise_q   <= 1'b0;
      scl_fall_q   <= 1'b0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      busy_q       <= 1'b0;
      byte_valid_q <= 1'b0;
      ack_valid_q  <= 1'b0;
      ack_bit_q    <= 1'b0;
      rx_byte_q    <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
    end else begin
      scl_rise_q   <= rise_c;
      scl_fall_q   <= fall_c;
      start_q      <= start_c;
      stop_q       <= stop_c;
      busy_q       <= (state_d == ST_BUSY);
      byte_valid_q <= 1'b0;
      ack_valid_q  <= 1'b0;
      if (start_c || stop_c) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (rise_c && state_q == ST_BUSY) begin
        if (bit_cnt == BIT_ACK) begin
          ack_bit_q   <= filt[1];
          ack_valid_q <= 1'b1;
          bit_cnt     <= '0;
        end else begin
          shreg   <= shift_c;
          bit_cnt <= bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_LAST) begin
            rx_byte_q    <= shift_c;
            byte_valid_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.scl_f      = filt[0];
  assign bus.sda_f      = filt[1];
  assign bus.scl_rise   = scl_rise_q;
  assign bus.scl_fall   = scl_fall_q;
  assign bus.start_det  = start_q;
  assign bus.stop_det   = stop_q;
  assign bus.bus_busy   = busy_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.rx_byte    = rx_byte_q;
  assign bus.ack_valid  = ack_valid_q;
  assign bus.ack_bit    = ack_bit_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Testbench for i2c_bus_monitor with FILTER_LEN=3.
// Directed I2C sequences push the events they expect into a queue. A separate
// monitor process pops that queue and compares each event whenever the DUT
// pulses start_det, stop_det, byte_valid or ack_valid. Filter latency, line
// state and reset values are checked directly at fixed cycle offsets.
module tb_i2c_bus_monitor;

  localparam logic [1:0] K_START = 2'd0;
  localparam logic [1:0] K_STOP  = 2'd1;
  localparam logic [1:0] K_BYTE  = 2'd2;
  localparam logic [1:0] K_ACK   = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } ev_t;

  logic clk_400 = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  ev_t  exp_q[$];

  i2c_bus_monitor_if bus ();

  i2c_bus_monitor #(.FILTER_LEN(3)) dut (
    .clk_400 (clk_400),
    .rst     (rst),
    .bus     (bus.slave)
  );

  always #5 clk_400 = ~clk_400;

  function automatic string kname(input logic [1:0] k);
    case (k)
      K_START: return "start";
      K_STOP:  return "stop";
      K_BYTE:  return "byte";
      default: return "ack";
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  task automatic push_exp(input logic [1:0] k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic got(input logic [1:0] k, input logic [7:0] d);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: actual %s %02h required none", kname(k), d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.data !== d) begin
        n_fail++;
        $display("FAIL event_order: actual %s %02h required %s %02h",
                 kname(k), d, kname(e.kind), e.data);
      end
    end
  endtask

  // Monitor: each event the DUT presents is scored against the queue.
  always @(negedge clk_400) begin
    if (!rst) begin
      if (bus.start_det)  got(K_START, 8'h00);
      if (bus.stop_det)   got(K_STOP, 8'h00);
      if (bus.byte_valid) got(K_BYTE, bus.rx_byte);
      if (bus.ack_valid)  got(K_ACK, {7'b0, bus.ack_bit});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_400);
    #1;
  endtask

  // One SCL clock: set SDA while SCL is low, then pulse SCL high.
  task automatic bit_tx(input logic b);
    bus.sda_in = b;
    tick(8);
    bus.scl_in = 1'b1;
    tick(10);
    bus.scl_in = 1'b0;
    tick(8);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic a, input bit expect_ev);
    if (expect_ev) begin
      push_exp(K_BYTE, v);
      push_exp(K_ACK, {7'b0, a});
    end
    for (int i = 7; i >= 0; i--) bit_tx(v[i]);
    bit_tx(a);
  endtask

  task automatic start_from_idle();
    bus.sda_in = 1'b1;
    tick(8);
    bus.scl_in = 1'b1;
    tick(10);
    push_exp(K_START, 8'h00);
    bus.sda_in = 1'b0;
    tick(10);
    bus.scl_in = 1'b0;
    tick(8);
  endtask

  task automatic stop_cond();
    bus.sda_in = 1'b0;
    tick(8);
    bus.scl_in = 1'b1;
    tick(10);
    push_exp(K_STOP, 8'h00);
    bus.sda_in = 1'b1;
    tick(10);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_lines"}, {30'b0, bus.scl_f, bus.sda_f}, 32'h3);
    chk({tag, "_pulses"}, {25'b0, bus.scl_rise, bus.scl_fall, bus.start_det,
        bus.stop_det, bus.byte_valid, bus.ack_valid, bus.bus_busy}, 32'h0);
    chk({tag, "_data"}, {23'b0, bus.rx_byte, bus.ack_bit}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen_low;
    logic found;
    rst        = 1'b1;
    bus.scl_in = 1'b1;
    bus.sda_in = 1'b1;
    tick(4);
    @(negedge clk_400);
    check_reset_values("reset");
    tick(1);
    rst = 1'b0;
    tick(6);

    // Glitch: a 2-cycle SDA low pulse with SCL high must be filtered out.
    bus.sda_in = 1'b0;
    tick(2);
    bus.sda_in = 1'b1;
    seen_low = 1'b0;
    repeat (12) begin
      @(negedge clk_400);
      if (!bus.sda_f) seen_low = 1'b1;
    end
    chk("glitch_sda_f_low_seen", {31'b0, seen_low}, 32'h0);
    chk("glitch_drain", exp_q.size(), 0);

    // Latency: sda_f falls 5 cycles after the raw edge and start_det follows.
    tick(1);
    push_exp(K_START, 8'h00);
    bus.sda_in = 1'b0;
    repeat (5) @(negedge clk_400);
    chk("lat_sda_f_before", {31'b0, bus.sda_f}, 32'h1);
    @(negedge clk_400);
    chk("lat_sda_f_after", {31'b0, bus.sda_f}, 32'h0);
    chk("lat_start_early", {31'b0, bus.start_det}, 32'h0);
    @(negedge clk_400);
    chk("lat_start_pulse", {31'b0, bus.start_det}, 32'h1);
    chk("lat_busy", {31'b0, bus.bus_busy}, 32'h1);

    // Byte: address 0x02 with ACK.
    tick(1);
    bus.scl_in = 1'b0;
    tick(8);
    send_byte(8'h02, 1'b0, 1'b1);
    chk("byte_rx", {24'b0, bus.rx_byte}, 32'h02);
    chk("byte_ack", {31'b0, bus.ack_bit}, 32'h0);
    chk("byte_drain", exp_q.size(), 0);

    // Repeated START after 3 bits, then 0xA5 with NACK.
    bit_tx(1'b1);
    bit_tx(1'b0);
    bit_tx(1'b1);
    start_from_idle();
    chk("rstart_busy", {31'b0, bus.bus_busy}, 32'h1);
    send_byte(8'hA5, 1'b1, 1'b1);
    chk("rstart_rx", {24'b0, bus.rx_byte}, 32'hA5);
    chk("rstart_ack", {31'b0, bus.ack_bit}, 32'h1);
    chk("rstart_busy_after", {31'b0, bus.bus_busy}, 32'h1);
    chk("rstart_drain", exp_q.size(), 0);

    // STOP, then SCL toggling while idle must not assemble anything.
    stop_cond();
    chk("stop_busy", {31'b0, bus.bus_busy}, 32'h0);
    bus.scl_in = 1'b0;
    tick(8);
    send_byte(8'hAA, 1'b0, 1'b0);
    bus.sda_in = 1'b1;
    tick(8);
    bus.scl_in = 1'b1;
    tick(10);
    chk("idle_busy", {31'b0, bus.bus_busy}, 32'h0);
    chk("idle_rx_unchanged", {24'b0, bus.rx_byte}, 32'hA5);
    chk("idle_drain", exp_q.size(), 0);

    // Simultaneous SCL fall and SDA rise: SCL edge only, no STOP.
    push_exp(K_START, 8'h00);
    bus.sda_in = 1'b0;
    tick(10);
    bus.scl_in = 1'b0;
    bus.sda_in = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_400);
      if (bus.scl_fall) found = 1'b1;
    end
    chk("simul_scl_fall", {31'b0, found}, 32'h1);
    chk("simul_busy", {31'b0, bus.bus_busy}, 32'h1);
    chk("simul_lines", {30'b0, bus.scl_f, bus.sda_f}, 32'h1);
    chk("simul_drain", exp_q.size(), 0);

    // Reset mid-byte: outputs clear, then nothing until a fresh START.
    tick(1);
    bit_tx(1'b1);
    bit_tx(1'b0);
    bit_tx(1'b1);
    bit_tx(1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk_400);
    check_reset_values("midrst");
    tick(3);
    bus.sda_in = 1'b1;
    rst = 1'b0;
    tick(10);
    chk("postrst_busy", {31'b0, bus.bus_busy}, 32'h0);
    send_byte(8'h5A, 1'b0, 1'b0);
    chk("postrst_rx", {24'b0, bus.rx_byte}, 32'h00);
    chk("postrst_drain", exp_q.size(), 0);
    start_from_idle();
    send_byte(8'h3C, 1'b0, 1'b1);
    stop_cond();
    tick(20);
    chk("final_rx", {24'b0, bus.rx_byte}, 32'h3C);
    chk("final_busy", {31'b0, bus.bus_busy}, 32'h0);
    chk("final_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
